// File: rtl/spi_engine_interconnect_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_engine_interconnect_arb_pkg
//   Shared SPI Engine constants for the N-port interconnect arbiter:
//   arbitration mode encodings, command/sync stream widths, the arbiter
//   FSM state type and a small modulo-increment helper.
// -----------------------------------------------------------------------------
package spi_engine_interconnect_arb_pkg;

    localparam int unsigned ARB_MODE_FIXED = 0;
    localparam int unsigned ARB_MODE_RR    = 1;

    localparam int unsigned SPI_CMD_WIDTH  = 16;
    localparam int unsigned SPI_SYNC_WIDTH = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACTIVE = 1'b1
    } arb_state_e;

    // v+1 wrapped into 0..n-1
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/spi_engine_interconnect_arb_sel.sv
// -----------------------------------------------------------------------------
// spi_engine_interconnect_arb_sel
//   Combinational winner selection for the interconnect arbiter.
//   Ports:
//     req_i      - per-slave request vector (s_cmd_valid)
//     rr_ptr_i   - round-robin search start index
//     mode_i     - 0: fixed priority (lowest index), 1: round-robin from rr_ptr_i
//     winner_o   - index of the selected requester (0 when none)
//     any_req_o  - at least one request is present
// -----------------------------------------------------------------------------
module spi_engine_interconnect_arb_sel
    import spi_engine_interconnect_arb_pkg::*;
#(
    parameter int unsigned NUM_OF_SLAVES = 2
) (
    input  logic [NUM_OF_SLAVES-1:0]         req_i,
    input  logic [$clog2(NUM_OF_SLAVES)-1:0] rr_ptr_i,
    input  logic                             mode_i,
    output logic [$clog2(NUM_OF_SLAVES)-1:0] winner_o,
    output logic                             any_req_o
);

    localparam int unsigned GW = $clog2(NUM_OF_SLAVES);

    logic        found;
    int unsigned start;
    int unsigned idx;

    // Scan N positions starting at 'start'; the first requester seen wins.
    // Fixed priority is the same scan anchored at index 0.
    always_comb begin
        winner_o  = '0;
        any_req_o = |req_i;
        found     = 1'b0;
        start     = mode_i ? int'(rr_ptr_i) : 0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_OF_SLAVES; i++) begin
            idx = (start + i) % NUM_OF_SLAVES;
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_o = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_engine_interconnect_arb.sv
// -----------------------------------------------------------------------------
// spi_engine_interconnect_arb
//   N-port SPI Engine interconnect. Arbitrates NUM_OF_SLAVES cmd/sdo/sdi/sync
//   stream sources onto one spi_engine_execution core. A grant is taken on the
//   first command request seen in IDLE and held until the core's SYNC
//   handshake, regardless of what the owner does with s_cmd_valid meanwhile.
//   Ports:
//     clk, resetn                 - clock, asynchronous active-low reset
//     m_cmd_*, m_sdo_*            - streams to the core, muxed from slave 'grant'
//     m_sdi_*, m_sync_*           - streams from the core, valid routed to
//                                   slave 'grant', data fanned out to all
//     s_cmd_*, s_sdo_*            - packed slave source streams (slave k at
//                                   bit k / slice k)
//     s_sdi_*, s_sync_*           - packed slave sink streams
//     grant                       - current or last owner index
//     busy                        - a transaction is in progress
// -----------------------------------------------------------------------------
module spi_engine_interconnect_arb
    import spi_engine_interconnect_arb_pkg::*;
#(
    parameter int unsigned NUM_OF_SLAVES = 2,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned NUM_OF_SDI    = 1,
    parameter int unsigned ARB_MODE      = 0
) (
    input  logic                                         clk,
    input  logic                                         resetn,

    output logic                                         m_cmd_valid,
    input  logic                                         m_cmd_ready,
    output logic [SPI_CMD_WIDTH-1:0]                     m_cmd_data,

    output logic                                         m_sdo_valid,
    input  logic                                         m_sdo_ready,
    output logic [DATA_WIDTH-1:0]                        m_sdo_data,

    input  logic                                         m_sdi_valid,
    output logic                                         m_sdi_ready,
    input  logic [DATA_WIDTH*NUM_OF_SDI-1:0]             m_sdi_data,

    input  logic                                         m_sync_valid,
    output logic                                         m_sync_ready,
    input  logic [SPI_SYNC_WIDTH-1:0]                    m_sync,

    input  logic [NUM_OF_SLAVES-1:0]                     s_cmd_valid,
    output logic [NUM_OF_SLAVES-1:0]                     s_cmd_ready,
    input  logic [SPI_CMD_WIDTH*NUM_OF_SLAVES-1:0]       s_cmd_data,

    input  logic [NUM_OF_SLAVES-1:0]                     s_sdo_valid,
    output logic [NUM_OF_SLAVES-1:0]                     s_sdo_ready,
    input  logic [DATA_WIDTH*NUM_OF_SLAVES-1:0]          s_sdo_data,

    output logic [NUM_OF_SLAVES-1:0]                     s_sdi_valid,
    input  logic [NUM_OF_SLAVES-1:0]                     s_sdi_ready,
    output logic [DATA_WIDTH*NUM_OF_SDI*NUM_OF_SLAVES-1:0] s_sdi_data,

    output logic [NUM_OF_SLAVES-1:0]                     s_sync_valid,
    input  logic [NUM_OF_SLAVES-1:0]                     s_sync_ready,
    output logic [SPI_SYNC_WIDTH*NUM_OF_SLAVES-1:0]      s_sync,

    output logic [$clog2(NUM_OF_SLAVES)-1:0]             grant,
    output logic                                         busy
);

    localparam int unsigned GW   = $clog2(NUM_OF_SLAVES);
    localparam int unsigned SDIW = DATA_WIDTH * NUM_OF_SDI;

    arb_state_e        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [GW-1:0]     winner;
    logic              any_req;
    logic              active;
    logic              sync_hs;
    logic [NUM_OF_SLAVES-1:0] owner_sel;

    logic              own_cmd_valid;
    logic              own_sdo_valid;
    logic              own_sdi_ready;
    logic              own_sync_ready;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    spi_engine_interconnect_arb_sel #(
        .NUM_OF_SLAVES (NUM_OF_SLAVES)
    ) u_sel (
        .req_i     (s_cmd_valid),
        .rr_ptr_i  (rr_ptr_q),
        .mode_i    (ARB_MODE == ARB_MODE_RR),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // ------------------------------------------------------------------
    // FSM: state, grant and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // The release edge always lands in IDLE, so a request present in the
    // same cycle as the SYNC handshake is only arbitrated one cycle later.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = ARB_ACTIVE;
                end
            end
            ARB_ACTIVE: begin
                if (sync_hs) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = GW'(wrap_inc(int'(grant_q), NUM_OF_SLAVES));
                end
            end
        endcase
    end

    assign active  = (state_q == ARB_ACTIVE);
    assign busy    = active;
    assign grant   = grant_q;
    assign sync_hs = m_sync_valid & m_sync_ready;

    // ------------------------------------------------------------------
    // Owner-side mux: everything keyed off registered grant/state only,
    // so no path exists from any ready input to m_cmd_valid.
    // ------------------------------------------------------------------
    always_comb begin
        own_cmd_valid  = 1'b0;
        own_sdo_valid  = 1'b0;
        own_sdi_ready  = 1'b0;
        own_sync_ready = 1'b0;
        m_cmd_data     = '0;
        m_sdo_data     = '0;
        for (int unsigned k = 0; k < NUM_OF_SLAVES; k++) begin
            if (owner_sel[k]) begin
                own_cmd_valid  = s_cmd_valid[k];
                own_sdo_valid  = s_sdo_valid[k];
                own_sdi_ready  = s_sdi_ready[k];
                own_sync_ready = s_sync_ready[k];
                m_cmd_data     = s_cmd_data[k*SPI_CMD_WIDTH +: SPI_CMD_WIDTH];
                m_sdo_data     = s_sdo_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign m_cmd_valid  = active & own_cmd_valid;
    assign m_sdo_valid  = active & own_sdo_valid;
    assign m_sdi_ready  = active & own_sdi_ready;
    assign m_sync_ready = active & own_sync_ready;

    // ------------------------------------------------------------------
    // Per-slave routing and fan-out
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_OF_SLAVES; k++) begin : g_slave
        assign owner_sel[k]    = (int'(grant_q) == k);
        assign s_cmd_ready[k]  = active & owner_sel[k] & m_cmd_ready;
        assign s_sdo_ready[k]  = active & owner_sel[k] & m_sdo_ready;
        assign s_sdi_valid[k]  = active & owner_sel[k] & m_sdi_valid;
        assign s_sync_valid[k] = active & owner_sel[k] & m_sync_valid;
        assign s_sdi_data[k*SDIW +: SDIW] = m_sdi_data;
        assign s_sync[k*SPI_SYNC_WIDTH +: SPI_SYNC_WIDTH] = m_sync;
    end

endmodule

// File: tb/tb_spi_engine_interconnect_arb.sv
// -----------------------------------------------------------------------------
// tb_spi_engine_interconnect_arb
//   Two DUTs (N=4, DATA_WIDTH=16, NUM_OF_SDI=2): index 0 fixed priority,
//   index 1 round-robin. Directed scenarios plus a randomized run against a
//   transaction-level model (owner / busy / pointer per DUT).
// -----------------------------------------------------------------------------
module tb_spi_engine_interconnect_arb;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned NSDI = 2;
    localparam int unsigned SDIW = DW * NSDI;

    logic clk;
    logic resetn;

    logic              m_cmd_valid  [2];
    logic              m_cmd_ready  [2];
    logic [15:0]       m_cmd_data   [2];
    logic              m_sdo_valid  [2];
    logic              m_sdo_ready  [2];
    logic [DW-1:0]     m_sdo_data   [2];
    logic              m_sdi_valid  [2];
    logic              m_sdi_ready  [2];
    logic [SDIW-1:0]   m_sdi_data   [2];
    logic              m_sync_valid [2];
    logic              m_sync_ready [2];
    logic [7:0]        m_sync       [2];
    logic [N-1:0]      s_cmd_valid  [2];
    logic [N-1:0]      s_cmd_ready  [2];
    logic [16*N-1:0]   s_cmd_data   [2];
    logic [N-1:0]      s_sdo_valid  [2];
    logic [N-1:0]      s_sdo_ready  [2];
    logic [DW*N-1:0]   s_sdo_data   [2];
    logic [N-1:0]      s_sdi_valid  [2];
    logic [N-1:0]      s_sdi_ready  [2];
    logic [SDIW*N-1:0] s_sdi_data   [2];
    logic [N-1:0]      s_sync_valid [2];
    logic [N-1:0]      s_sync_ready [2];
    logic [8*N-1:0]    s_sync       [2];
    logic [1:0]        grant        [2];
    logic              busy         [2];

    int tests_run;
    int tests_failed;

    // Transaction-level model per DUT
    bit          mbusy  [2];
    int unsigned mgrant [2];
    int unsigned mptr   [2];

    spi_engine_interconnect_arb #(
        .NUM_OF_SLAVES (N), .DATA_WIDTH (DW), .NUM_OF_SDI (NSDI), .ARB_MODE (0)
    ) u_fix (
        .clk (clk), .resetn (resetn),
        .m_cmd_valid (m_cmd_valid[0]), .m_cmd_ready (m_cmd_ready[0]), .m_cmd_data (m_cmd_data[0]),
        .m_sdo_valid (m_sdo_valid[0]), .m_sdo_ready (m_sdo_ready[0]), .m_sdo_data (m_sdo_data[0]),
        .m_sdi_valid (m_sdi_valid[0]), .m_sdi_ready (m_sdi_ready[0]), .m_sdi_data (m_sdi_data[0]),
        .m_sync_valid (m_sync_valid[0]), .m_sync_ready (m_sync_ready[0]), .m_sync (m_sync[0]),
        .s_cmd_valid (s_cmd_valid[0]), .s_cmd_ready (s_cmd_ready[0]), .s_cmd_data (s_cmd_data[0]),
        .s_sdo_valid (s_sdo_valid[0]), .s_sdo_ready (s_sdo_ready[0]), .s_sdo_data (s_sdo_data[0]),
        .s_sdi_valid (s_sdi_valid[0]), .s_sdi_ready (s_sdi_ready[0]), .s_sdi_data (s_sdi_data[0]),
        .s_sync_valid (s_sync_valid[0]), .s_sync_ready (s_sync_ready[0]), .s_sync (s_sync[0]),
        .grant (grant[0]), .busy (busy[0])
    );

    spi_engine_interconnect_arb #(
        .NUM_OF_SLAVES (N), .DATA_WIDTH (DW), .NUM_OF_SDI (NSDI), .ARB_MODE (1)
    ) u_rr (
        .clk (clk), .resetn (resetn),
        .m_cmd_valid (m_cmd_valid[1]), .m_cmd_ready (m_cmd_ready[1]), .m_cmd_data (m_cmd_data[1]),
        .m_sdo_valid (m_sdo_valid[1]), .m_sdo_ready (m_sdo_ready[1]), .m_sdo_data (m_sdo_data[1]),
        .m_sdi_valid (m_sdi_valid[1]), .m_sdi_ready (m_sdi_ready[1]), .m_sdi_data (m_sdi_data[1]),
        .m_sync_valid (m_sync_valid[1]), .m_sync_ready (m_sync_ready[1]), .m_sync (m_sync[1]),
        .s_cmd_valid (s_cmd_valid[1]), .s_cmd_ready (s_cmd_ready[1]), .s_cmd_data (s_cmd_data[1]),
        .s_sdo_valid (s_sdo_valid[1]), .s_sdo_ready (s_sdo_ready[1]), .s_sdo_data (s_sdo_data[1]),
        .s_sdi_valid (s_sdi_valid[1]), .s_sdi_ready (s_sdi_ready[1]), .s_sdi_data (s_sdi_data[1]),
        .s_sync_valid (s_sync_valid[1]), .s_sync_ready (s_sync_ready[1]), .s_sync (s_sync[1]),
        .grant (grant[1]), .busy (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Winner per the arbitration rule: first requester found scanning from
    // the start point (0 for fixed priority, pointer for round-robin).
    function automatic int unsigned pick(input logic [N-1:0] req, input int unsigned ptr, input bit rr);
        int unsigned s;
        s = rr ? ptr : 0;
        for (int unsigned i = 0; i < N; i++)
            if (req[(s + i) % N]) return (s + i) % N;
        return 0;
    endfunction

    task automatic idle_inputs(input int d);
        m_cmd_ready[d]  = 1'b0; m_sdo_ready[d]  = 1'b0;
        m_sdi_valid[d]  = 1'b0; m_sdi_data[d]   = '0;
        m_sync_valid[d] = 1'b0; m_sync[d]       = '0;
        s_cmd_valid[d]  = '0;   s_cmd_data[d]   = '0;
        s_sdo_valid[d]  = '0;   s_sdo_data[d]   = '0;
        s_sdi_ready[d]  = '0;   s_sync_ready[d] = '0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mbusy[d] = 1'b0; mgrant[d] = 0; mptr[d] = 0;
        end
    endtask

    // One clock edge; model advances from the inputs held across the edge.
    task automatic tick();
        @(posedge clk);
        if (resetn) begin
            for (int d = 0; d < 2; d++) begin
                if (!mbusy[d]) begin
                    if (s_cmd_valid[d] != '0) begin
                        mgrant[d] = pick(s_cmd_valid[d], mptr[d], d == 1);
                        mbusy[d]  = 1'b1;
                    end
                end else if (m_sync_valid[d] && s_sync_ready[d][mgrant[d]]) begin
                    mbusy[d] = 1'b0;
                    mptr[d]  = (mgrant[d] + 1) % N;
                end
            end
        end
        #1;
    endtask

    task automatic finish_txn(input int d);
        s_cmd_valid[d]  = '0;
        m_sync_valid[d] = 1'b1;
        s_sync_ready[d] = '1;
        tick();
        m_sync_valid[d] = 1'b0;
        s_sync_ready[d] = '0;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            idle_inputs(d);
            s_cmd_valid[d] = '1;
            m_cmd_ready[d] = 1'b1;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (grant[d] !== 2'd0 || busy[d] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_state dut%0d: grant=%0d busy=%0b, expected 0/0", d, grant[d], busy[d]);
            end
            tests_run++;
            if ({m_cmd_valid[d], m_sdo_valid[d], m_sdi_ready[d], m_sync_ready[d],
                 s_cmd_ready[d], s_sdo_ready[d], s_sdi_valid[d], s_sync_valid[d]} !== 20'd0) begin
                tests_failed++;
                $display("FAIL reset_handshakes dut%0d: some valid/ready is nonzero, expected all 0", d);
            end
            idle_inputs(d);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_fixed_priority();
        s_cmd_data[0]  = 64'h4444_3333_2222_1111;
        s_cmd_valid[0] = 4'b1010;
        m_cmd_ready[0] = 1'b1;
        #1;
        tests_run++;
        if (busy[0] !== 1'b0 || m_cmd_valid[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL fixed_no_comb_grant: busy=%0b m_cmd_valid=%0b, expected 0/0", busy[0], m_cmd_valid[0]);
        end
        tick();
        tests_run++;
        if (grant[0] !== 2'd1 || m_cmd_valid[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL fixed_grant: grant=%0d m_cmd_valid=%0b, expected 1/1", grant[0], m_cmd_valid[0]);
        end
        tests_run++;
        if (m_cmd_data[0] !== 16'h2222) begin
            tests_failed++;
            $display("FAIL fixed_cmd_data: got %h expected 2222", m_cmd_data[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (s_cmd_ready[0] !== 4'b0010) begin
                tests_failed++;
                $display("FAIL fixed_ready cycle %0d: s_cmd_ready=%b expected 0010", i, s_cmd_ready[0]);
            end
            tick();
        end
        m_sync_valid[0] = 1'b1;
        s_sync_ready[0] = 4'b0010;
        #1;
        tests_run++;
        if (m_sync_ready[0] !== 1'b1 || s_sync_valid[0] !== 4'b0010) begin
            tests_failed++;
            $display("FAIL fixed_sync_route: m_sync_ready=%0b s_sync_valid=%b expected 1/0010",
                     m_sync_ready[0], s_sync_valid[0]);
        end
        tick();
        s_cmd_valid[0]  = '0;
        m_sync_valid[0] = 1'b0;
        s_sync_ready[0] = '0;
        #1;
        tests_run++;
        if (busy[0] !== 1'b0 || grant[0] !== 2'd1) begin
            tests_failed++;
            $display("FAIL fixed_release: busy=%0b grant=%0d expected 0/1", busy[0], grant[0]);
        end
        idle_inputs(0);
    endtask

    task automatic test_sync_same_cycle();
        s_cmd_valid[0] = 4'b0001;
        tick();
        s_cmd_valid[0]  = 4'b0100;
        m_sync_valid[0] = 1'b1;
        s_sync_ready[0] = 4'b0001;
        #1;
        tests_run++;
        if (busy[0] !== 1'b1 || grant[0] !== 2'd0) begin
            tests_failed++;
            $display("FAIL samecyc_hold: busy=%0b grant=%0d expected 1/0", busy[0], grant[0]);
        end
        tick();
        m_sync_valid[0] = 1'b0;
        #1;
        tests_run++;
        if (busy[0] !== 1'b0 || m_cmd_valid[0] !== 1'b0 || grant[0] !== 2'd0) begin
            tests_failed++;
            $display("FAIL samecyc_bubble: busy=%0b m_cmd_valid=%0b grant=%0d expected 0/0/0",
                     busy[0], m_cmd_valid[0], grant[0]);
        end
        tick();
        tests_run++;
        if (busy[0] !== 1'b1 || grant[0] !== 2'd2 || m_cmd_valid[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL samecyc_regrant: busy=%0b grant=%0d m_cmd_valid=%0b expected 1/2/1",
                     busy[0], grant[0], m_cmd_valid[0]);
        end
        finish_txn(0);
        idle_inputs(0);
    endtask

    task automatic test_sdi_fanout();
        logic [SDIW-1:0] slice;
        s_cmd_valid[0] = 4'b0010;
        tick();
        m_sdi_data[0]  = 32'hA5A5_3C3C;
        m_sdi_valid[0] = 1'b1;
        s_sdi_ready[0] = 4'b0010;
        m_sync[0]      = 8'h5A;
        #1;
        tests_run++;
        if (s_sdi_valid[0] !== 4'b0010 || m_sdi_ready[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sdi_route: s_sdi_valid=%b m_sdi_ready=%0b expected 0010/1",
                     s_sdi_valid[0], m_sdi_ready[0]);
        end
        for (int k = 0; k < N; k++) begin
            slice = s_sdi_data[0][k*SDIW +: SDIW];
            tests_run++;
            if (slice !== 32'hA5A5_3C3C) begin
                tests_failed++;
                $display("FAIL sdi_fanout slave%0d: got %h expected a5a53c3c", k, slice);
            end
        end
        tests_run++;
        if (s_sync[0] !== 32'h5A5A_5A5A) begin
            tests_failed++;
            $display("FAIL sync_fanout: got %h expected 5a5a5a5a", s_sync[0]);
        end
        s_sdi_ready[0] = 4'b1101;
        #1;
        tests_run++;
        if (m_sdi_ready[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL sdi_ready_owner_only: m_sdi_ready=%0b expected 0", m_sdi_ready[0]);
        end
        m_sdi_valid[0] = 1'b0;
        s_sdi_ready[0] = '0;
        finish_txn(0);
        idle_inputs(0);
    endtask

    task automatic test_owner_drop();
        s_cmd_valid[0] = 4'b0100;
        m_cmd_ready[0] = 1'b1;
        tick();
        s_cmd_valid[0] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (grant[0] !== 2'd2 || busy[0] !== 1'b1 || m_cmd_valid[0] !== 1'b0 ||
                s_cmd_ready[0] !== 4'b0100) begin
                tests_failed++;
                $display("FAIL owner_drop cycle %0d: grant=%0d busy=%0b m_cmd_valid=%0b s_cmd_ready=%b expected 2/1/0/0100",
                         i, grant[0], busy[0], m_cmd_valid[0], s_cmd_ready[0]);
            end
            tick();
        end
        m_sync_valid[0] = 1'b1;
        s_sync_ready[0] = '1;
        tick();
        m_sync_valid[0] = 1'b0;
        #1;
        tests_run++;
        if (busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL owner_drop_release: busy=%0b expected 0", busy[0]);
        end
        tick();
        tests_run++;
        if (grant[0] !== 2'd0 || busy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL owner_drop_next: grant=%0d busy=%0b expected 0/1", grant[0], busy[0]);
        end
        finish_txn(0);
        idle_inputs(0);
    endtask

    task automatic test_rr_sequence();
        int unsigned exp_g [5];
        exp_g = '{0, 1, 2, 3, 0};
        s_cmd_valid[1] = 4'hF;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (grant[1] !== 2'(exp_g[i]) || busy[1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_grant step %0d: grant=%0d busy=%0b expected %0d/1", i, grant[1], busy[1], exp_g[i]);
            end
            m_sync_valid[1] = 1'b1;
            s_sync_ready[1] = 4'hF;
            tick();
            m_sync_valid[1] = 1'b0;
            #1;
            tests_run++;
            if (busy[1] !== 1'b0 || m_cmd_valid[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_bubble step %0d: busy=%0b m_cmd_valid=%0b expected 0/0", i, busy[1], m_cmd_valid[1]);
            end
        end
        idle_inputs(1);
    endtask

    task automatic test_async_reset();
        s_cmd_valid[1] = 4'b1000;
        m_cmd_ready[1] = 1'b1;
        m_sdi_valid[1] = 1'b1;
        tick();
        tests_run++;
        if (grant[1] !== 2'd3 || busy[1] !== 1'b1 || m_cmd_valid[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_pre: grant=%0d busy=%0b m_cmd_valid=%0b expected 3/1/1",
                     grant[1], busy[1], m_cmd_valid[1]);
        end
        #1 resetn = 1'b0;
        #1;
        tests_run++;
        if (grant[1] !== 2'd0 || busy[1] !== 1'b0 || m_cmd_valid[1] !== 1'b0 ||
            s_cmd_ready[1] !== 4'b0 || s_sdi_valid[1] !== 4'b0) begin
            tests_failed++;
            $display("FAIL areset_async: grant=%0d busy=%0b m_cmd_valid=%0b s_cmd_ready=%b s_sdi_valid=%b expected all 0",
                     grant[1], busy[1], m_cmd_valid[1], s_cmd_ready[1], s_sdi_valid[1]);
        end
        idle_inputs(0);
        idle_inputs(1);
        model_reset();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int unsigned g;
        bit          b;
        logic [19:0] exp_hs;
        logic [N-1:0] oh;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                s_cmd_valid[d]  = ($urandom_range(0, 2) == 0) ? 4'(($urandom_range(0, 15))) : 4'b0;
                s_cmd_data[d]   = {$urandom, $urandom};
                s_sdo_valid[d]  = 4'($urandom_range(0, 15));
                s_sdo_data[d]   = {$urandom, $urandom};
                s_sdi_ready[d]  = 4'($urandom_range(0, 15));
                s_sync_ready[d] = 4'($urandom_range(0, 15));
                m_cmd_ready[d]  = 1'($urandom_range(0, 1));
                m_sdo_ready[d]  = 1'($urandom_range(0, 1));
                m_sdi_valid[d]  = 1'($urandom_range(0, 1));
                m_sdi_data[d]   = $urandom;
                m_sync_valid[d] = ($urandom_range(0, 3) == 0);
                m_sync[d]       = 8'($urandom_range(0, 255));
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                g  = mgrant[d];
                b  = mbusy[d];
                oh = 4'(1 << g);
                exp_hs = {b & s_cmd_valid[d][g], b & s_sdo_valid[d][g],
                          b & s_sdi_ready[d][g], b & s_sync_ready[d][g],
                          (b & m_cmd_ready[d])  ? oh : 4'b0,
                          (b & m_sdo_ready[d])  ? oh : 4'b0,
                          (b & m_sdi_valid[d])  ? oh : 4'b0,
                          (b & m_sync_valid[d]) ? oh : 4'b0};
                tests_run++;
                if (grant[d] !== 2'(g)) begin
                    tests_failed++;
                    $display("FAIL rand_grant dut%0d cyc %0d: got %0d expected %0d", d, cyc, grant[d], g);
                end
                tests_run++;
                if (busy[d] !== b) begin
                    tests_failed++;
                    $display("FAIL rand_busy dut%0d cyc %0d: got %0b expected %0b", d, cyc, busy[d], b);
                end
                tests_run++;
                if ({m_cmd_valid[d], m_sdo_valid[d], m_sdi_ready[d], m_sync_ready[d],
                     s_cmd_ready[d], s_sdo_ready[d], s_sdi_valid[d], s_sync_valid[d]} !== exp_hs) begin
                    tests_failed++;
                    $display("FAIL rand_handshake dut%0d cyc %0d: got %h expected %h", d, cyc,
                             {m_cmd_valid[d], m_sdo_valid[d], m_sdi_ready[d], m_sync_ready[d],
                              s_cmd_ready[d], s_sdo_ready[d], s_sdi_valid[d], s_sync_valid[d]}, exp_hs);
                end
                tests_run++;
                if (m_cmd_data[d] !== s_cmd_data[d][16*g +: 16] ||
                    m_sdo_data[d] !== s_sdo_data[d][DW*g +: DW] ||
                    s_sdi_data[d] !== {N{m_sdi_data[d]}} ||
                    s_sync[d]     !== {N{m_sync[d]}}) begin
                    tests_failed++;
                    $display("FAIL rand_data dut%0d cyc %0d: cmd=%h sdo=%h expected cmd=%h sdo=%h (or fan-out wrong)",
                             d, cyc, m_cmd_data[d], m_sdo_data[d],
                             s_cmd_data[d][16*g +: 16], s_sdo_data[d][DW*g +: DW]);
                end
            end
            tick();
        end
        idle_inputs(0);
        idle_inputs(1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        model_reset();
        test_reset();
        test_fixed_priority();
        test_sync_same_cycle();
        test_sdi_fanout();
        test_owner_drop();
        test_rr_sequence();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_engine_interconnect_arb.md
# spi_engine_interconnect_arb

Parametrised N-port SPI Engine interconnect: arbitrates between `NUM_OF_SLAVES` command/SDO/SDI/SYNC stream sources and forwards the winner to a single SPI Engine execution core. Sits between the offload and host-interface stream producers and `spi_engine_execution`. A grant is held for a whole transaction, from the first command accepted until the core's SYNC handshake. Arbitration is fixed-priority or round-robin.

## Interface
- `NUM_OF_SLAVES`, 2: number of slave ports, 2..8.
- `DATA_WIDTH`, 8: SDO/SDI word width per lane, 8..32.
- `NUM_OF_SDI`, 1: SDI lanes, 1..8; SDI bus width is `DATA_WIDTH*NUM_OF_SDI`.
- `ARB_MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `clk` in 1: single clock. All logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `m_cmd_valid`/`m_cmd_ready`/`m_cmd_data` out/in/out 1/1/16: command stream to the core.
- `m_sdo_valid`/`m_sdo_ready`/`m_sdo_data` out/in/out 1/1/`DATA_WIDTH`.
- `m_sdi_valid`/`m_sdi_ready`/`m_sdi_data` in/out/in 1/1/`DATA_WIDTH*NUM_OF_SDI`.
- `m_sync_valid`/`m_sync_ready`/`m_sync` in/out/in 1/1/8.
- `s_cmd_valid`/`s_cmd_ready`/`s_cmd_data` in/out/in `N`/`N`/`16*N`: packed slave command streams. Slave k occupies bit k and slice `[16k+15:16k]`.
- `s_sdo_*` in/out/in `N`/`N`/`DATA_WIDTH*N`: packed the same way.
- `s_sdi_*` out/in/out `N`/`N`/`DATA_WIDTH*NUM_OF_SDI*N`.
- `s_sync_*` out/in/out `N`/`N`/`8*N`.
- `grant` out `clog2(N)`: index of the current or last owner.
- `busy` out 1: a transaction is in progress.

## Operation
- States: IDLE, ACTIVE.
- In IDLE:
  - All `m_*_valid`, `m_*_ready`, `s_*_ready` and `s_sdi_valid`/`s_sync_valid` are 0.
  - When any `s_cmd_valid` is 1, the arbiter picks a winner, registers it in `grant`, and moves to ACTIVE on the next edge.
- In ACTIVE:
  - The `cmd`/`sdo` valid and data of slave `grant` drive `m_*`.
  - `m_cmd_ready`/`m_sdo_ready` route back to slave `grant` only; the other slaves' ready is 0.
  - `m_sdi_valid`/`m_sync_valid` route to slave `grant` only; `m_sdi_ready`/`m_sync_ready` are taken from slave `grant`.
  - SDI and SYNC data fan out to every slave unmuxed.
- ACTIVE → IDLE on the edge where `m_sync_valid && m_sync_ready`. Non-owner cmd_valid is ignored while ACTIVE.
- Fixed priority: the lowest index k with `s_cmd_valid[k]` wins.
- Round-robin: search starts at `rr_ptr` and wraps modulo N. On release, `rr_ptr <= grant+1` (wraps N-1 → 0).
- `m_*_data` always shows slave `grant`'s data, even in IDLE.
- An owner dropping `s_cmd_valid` mid-transaction does not release the grant; only SYNC releases it.

## Timing
- Reset values: state IDLE, `grant`=0, `rr_ptr`=0, `busy`=0, all valid/ready outputs 0.
- Grant latency: `s_cmd_valid` seen in IDLE at edge n → `m_cmd_valid` high from edge n+1. One cycle, always registered.
- Release: the SYNC handshake at edge n gives IDLE from n+1. Arbitration then happens in that cycle, so the next owner's `m_cmd_valid` appears at n+2. There is exactly one bubble cycle between transactions.
- The SYNC handshake and a new request in the same cycle do not re-grant in that cycle.
- `m_cmd_valid` must not depend combinationally on `m_cmd_ready`. All muxes are combinational from the registered `grant` and state.
- Reset asserted mid-transaction: state, `grant` and `rr_ptr` clear at once and outputs drop to 0 asynchronously. Deassertion is synchronised by the integrator.

## Structure
- Shared SPI Engine header: `ARB_MODE_FIXED`=0, `ARB_MODE_RR`=1, and the command width constant 16.
- Sub-module `spi_engine_interconnect_arb_sel` is combinational. Inputs: request vector, `rr_ptr`, mode. Outputs: winner index and `any_req`.
- Top level holds the FSM, the `grant`/`rr_ptr` registers and the stream muxes, built with generate loops over N.

## Test plan
- N=4, fixed mode, `s_cmd_valid`=4'b1010 from IDLE → `grant`=1 and `m_cmd_valid` high one cycle later; slave 3 sees `s_cmd_ready`=0 throughout.
- N=4, RR mode, all four slaves request continuously, each finishing with a SYNC → grants 0,1,2,3,0; one idle cycle between each.
- SYNC handshake in the same cycle as a new `s_cmd_valid[2]` → IDLE for exactly one cycle, then `grant`=2.
- `NUM_OF_SDI`=2, `DATA_WIDTH`=16, owner slave 1, `m_sdi_data`=32'hA5A5_3C3C → `s_sdi_valid`=2'b10; both slaves' SDI data equal 32'hA5A5_3C3C.
- `resetn` low while ACTIVE with `grant`=3 → `grant`=0, `busy`=0 and all valid outputs 0 without waiting for a clock edge.
- Owner deasserts `s_cmd_valid` for 5 cycles mid-transaction while slave 0 requests → `grant` unchanged until the SYNC handshake.
